control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle instruction decoder and sequencer for the 8-bit processor. It accepts one 32-bit instruction at a time and decodes it into the operation select, operand-select and register-file control signals. It holds those signals stable while the ALU result settles, then commits one register write or one branch decision. It consumes the ALU's ZERO flag for BEQ/BNE.

## Interface
- LAT_FWD, 1: EXEC cycles for LOADI/MOV
- LAT_ADD, 2: EXEC cycles for ADD/SUB/BEQ/BNE
- LAT_LOGIC, 1: EXEC cycles for AND/OR
- LAT_MUL, 3: EXEC cycles for MULT
- LAT_SHIFT, 3: EXEC cycles for SLL/SRL/SRA/ROR
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- INSTR  in  32  instruction: [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/imm
- INSTR_VALID  in  1  INSTR is presented
- INSTR_READY  out  1  unit can accept an instruction
- ZERO  in  1  ALU zero flag (sum==0), sampled in COMMIT
- ALUOP  out  3  000 fwd, 001 add, 010 and, 011 or, 100 mul, 101 shift
- READ_ADDR1, READ_ADDR2  out  3 each  INSTR[10:8], INSTR[2:0]
- WRITE_ADDR  out  3  INSTR[18:16]
- IMM  out  8  immediate operand (shift-encoded for shifts)
- IMM_SEL  out  1  operand 2 = IMM (1) or register (0)
- NEG_SEL  out  1  operand 2 is two's-complemented (SUB/BEQ/BNE)
- WRITE_EN  out  1  one-cycle register-write strobe
- BRANCH_TAKEN  out  1  one-cycle PC-redirect strobe
- BRANCH_OFFSET  out  8  signed word offset, INSTR[23:16]
- BUSY  out  1  unit is not in IDLE
- ILLEGAL  out  1  one-cycle strobe for an undefined opcode

## Operation
- Opcodes:
  - 00 LOADI: fwd, IMM_SEL=1, IMM=INSTR[7:0].
  - 01 MOV: fwd.
  - 02 ADD: add.
  - 03 SUB: add, NEG_SEL=1.
  - 04 AND: and.
  - 05 OR: or.
  - 06 J: no ALU use, ALUOP=000.
  - 07 BEQ / 08 BNE: add, NEG_SEL=1.
  - 09 MULT: mul.
  - 0A SLL / 0B SRL / 0C SRA / 0D ROR: shift, IMM_SEL=1, IMM={2'b00, type, INSTR[3:0]} with type 00/01/10/11 respectively.
  - Any other opcode is illegal.
- Shift amount is passed through unchanged (0..15). An amount of 0 is legal and yields the operand unchanged in the ALU.
- FSM states: IDLE, EXEC, COMMIT.
  - IDLE: INSTR_READY=1. When INSTR_VALID=1, register the decoded fields, load the counter with the opcode's LAT_* value, and go to EXEC.
  - EXEC: decrement the counter each cycle; go to COMMIT when it reaches 1. Illegal opcodes use 1 cycle. J uses LAT_FWD.
  - COMMIT: one cycle, then back to IDLE.
    - WRITE_EN=1 for opcodes 00–05 and 09–0D.
    - BRANCH_TAKEN = 1 for J, ZERO for BEQ, ~ZERO for BNE.
    - ILLEGAL=1 for undefined opcodes, with no write and no branch.
- Decoded outputs (ALUOP, addresses, IMM, IMM_SEL, NEG_SEL, BRANCH_OFFSET) are registered. They stay stable from the cycle after accept through COMMIT, and hold their last values in IDLE.
- Unused fields are don't-care but must still be driven deterministically. WRITE_ADDR is decoded for branches but not strobed.

## Timing
- Reset (synchronous): state=IDLE; all outputs 0 except INSTR_READY, which is 1 in the first cycle after RESET is sampled low. The counter is cleared.
- Accept happens at edge 0. EXEC spans cycles 1..LAT and COMMIT is cycle LAT+1. INSTR_READY returns to 1 in cycle LAT+2. Throughput is one instruction per LAT+2 cycles.
- INSTR is sampled only at the accept edge. Later changes while BUSY are ignored.
- WRITE_EN, BRANCH_TAKEN and ILLEGAL are mutually exclusive and each is high for exactly one cycle.
- ZERO is sampled only in COMMIT. Glitches during EXEC are ignored.
- RESET during EXEC or COMMIT takes effect at the next edge: the instruction is dropped and no strobe is issued in that cycle. RESET has priority over accept.
- The counter never underflows. A LAT_* value of 0 is treated as 1.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants OP_LOADI..OP_ROR
  - ALUOP encodings
  - shift-type codes SH_SLL/SRL/SRA/ROR
  - FSM state enum
- Sub-module `ctrl_decode`: combinational opcode → {aluop, imm_sel, neg_sel, is_write, is_branch, branch_kind, illegal, latency} lookup.
- `control_unit` contains the FSM, the counter and the output registers.

## Test plan
- ADD, 0x02040102: ALUOP=001, READ_ADDR1=1, READ_ADDR2=2, WRITE_ADDR=4, IMM_SEL=0, NEG_SEL=0. WRITE_EN pulses in cycle 3; INSTR_READY=1 in cycle 4.
- LOADI, 0x000300F7: IMM=0xF7, IMM_SEL=1, ALUOP=000. WRITE_EN in cycle 2 with WRITE_ADDR=3.
- SRA, 0x0C050203: ALUOP=101, IMM=0x23, IMM_SEL=1. WRITE_EN in cycle 4.
- BEQ, 0x07FC0102:
  - With ZERO=1 in COMMIT: BRANCH_TAKEN=1, BRANCH_OFFSET=0xFC, NEG_SEL=1, WRITE_EN=0.
  - Repeated with ZERO=0: BRANCH_TAKEN=0.
  - BNE with ZERO=0: BRANCH_TAKEN=1.
- Opcode 0xFF: ILLEGAL pulses in cycle 2; no WRITE_EN, no BRANCH_TAKEN. Back-to-back INSTR_VALID held high: the next instruction is accepted in cycle 3.
- MULT, 0x09010203, with RESET asserted in EXEC cycle 2: all outputs 0 the following cycle and WRITE_EN never asserts. INSTR_READY=1 in the first cycle after RESET is sampled low.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor control path.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SHT_W   = 2;
  localparam int unsigned CNT_W   = 3;

  // EXEC-phase cycle counts per operation class
  localparam int unsigned LAT_FWD   = 1;
  localparam int unsigned LAT_ADD   = 2;
  localparam int unsigned LAT_LOGIC = 1;
  localparam int unsigned LAT_MUL   = 3;
  localparam int unsigned LAT_SHIFT = 3;

  localparam logic [OPC_W-1:0] OP_LOADI = 8'h00;
  localparam logic [OPC_W-1:0] OP_MOV   = 8'h01;
  localparam logic [OPC_W-1:0] OP_ADD   = 8'h02;
  localparam logic [OPC_W-1:0] OP_SUB   = 8'h03;
  localparam logic [OPC_W-1:0] OP_AND   = 8'h04;
  localparam logic [OPC_W-1:0] OP_OR    = 8'h05;
  localparam logic [OPC_W-1:0] OP_J     = 8'h06;
  localparam logic [OPC_W-1:0] OP_BEQ   = 8'h07;
  localparam logic [OPC_W-1:0] OP_BNE   = 8'h08;
  localparam logic [OPC_W-1:0] OP_MULT  = 8'h09;
  localparam logic [OPC_W-1:0] OP_SLL   = 8'h0A;
  localparam logic [OPC_W-1:0] OP_SRL   = 8'h0B;
  localparam logic [OPC_W-1:0] OP_SRA   = 8'h0C;
  localparam logic [OPC_W-1:0] OP_ROR   = 8'h0D;

  localparam logic [ALUOP_W-1:0] ALU_FWD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_MUL   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SHIFT = 3'b101;

  localparam logic [SHT_W-1:0] SH_SLL = 2'b00;
  localparam logic [SHT_W-1:0] SH_SRL = 2'b01;
  localparam logic [SHT_W-1:0] SH_SRA = 2'b10;
  localparam logic [SHT_W-1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_JUMP = 2'd1,
    BR_EQ   = 2'd2,
    BR_NE   = 2'd3
  } br_kind_t;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               imm_sel;
    logic               neg_sel;
    logic               is_write;
    logic               is_branch;
    br_kind_t           branch_kind;
    logic               illegal;
    logic [SHT_W-1:0]   sh_type;
    logic [CNT_W-1:0]   latency;
  } dec_t;

  // A zero latency would underflow the counter, so it is promoted to one cycle.
  function automatic logic [CNT_W-1:0] lat_cnt(input int unsigned lat);
    return (lat == 0) ? CNT_W'(1) : CNT_W'(lat);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode lookup: ALU select, operand controls, commit kind, latency.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output dec_t             o_dec
);

  // Opcode table; anything not listed is flagged illegal with a one-cycle EXEC.
  always_comb begin
    o_dec             = '0;
    o_dec.aluop       = ALU_FWD;
    o_dec.branch_kind = BR_NONE;
    o_dec.sh_type     = SH_SLL;
    o_dec.latency     = CNT_W'(1);
    case (i_opcode)
      OP_LOADI: begin
        o_dec.imm_sel  = 1'b1;
        o_dec.is_write = 1'b1;
        o_dec.latency  = lat_cnt(LAT_FWD);
      end
      OP_MOV: begin
        o_dec.is_write = 1'b1;
        o_dec.latency  = lat_cnt(LAT_FWD);
      end
      OP_ADD: begin
        o_dec.aluop    = ALU_ADD;
        o_dec.is_write = 1'b1;
        o_dec.latency  = lat_cnt(LAT_ADD);
      end
      OP_SUB: begin
        o_dec.aluop    = ALU_ADD;
        o_dec.neg_sel  = 1'b1;
        o_dec.is_write = 1'b1;
        o_dec.latency  = lat_cnt(LAT_ADD);
      end
      OP_AND: begin
        o_dec.aluop    = ALU_AND;
        o_dec.is_write = 1'b1;
        o_dec.latency  = lat_cnt(LAT_LOGIC);
      end
      OP_OR: begin
        o_dec.aluop    = ALU_OR;
        o_dec.is_write = 1'b1;
        o_dec.latency  = lat_cnt(LAT_LOGIC);
      end
      OP_J: begin
        o_dec.is_branch   = 1'b1;
        o_dec.branch_kind = BR_JUMP;
        o_dec.latency     = lat_cnt(LAT_FWD);
      end
      OP_BEQ: begin
        o_dec.aluop       = ALU_ADD;
        o_dec.neg_sel     = 1'b1;
        o_dec.is_branch   = 1'b1;
        o_dec.branch_kind = BR_EQ;
        o_dec.latency     = lat_cnt(LAT_ADD);
      end
      OP_BNE: begin
        o_dec.aluop       = ALU_ADD;
        o_dec.neg_sel     = 1'b1;
        o_dec.is_branch   = 1'b1;
        o_dec.branch_kind = BR_NE;
        o_dec.latency     = lat_cnt(LAT_ADD);
      end
      OP_MULT: begin
        o_dec.aluop    = ALU_MUL;
        o_dec.is_write = 1'b1;
        o_dec.latency  = lat_cnt(LAT_MUL);
      end
      OP_SLL: begin
        o_dec.aluop    = ALU_SHIFT;
        o_dec.imm_sel  = 1'b1;
        o_dec.is_write = 1'b1;
        o_dec.sh_type  = SH_SLL;
        o_dec.latency  = lat_cnt(LAT_SHIFT);
      end
      OP_SRL: begin
        o_dec.aluop    = ALU_SHIFT;
        o_dec.imm_sel  = 1'b1;
        o_dec.is_write = 1'b1;
        o_dec.sh_type  = SH_SRL;
        o_dec.latency  = lat_cnt(LAT_SHIFT);
      end
      OP_SRA: begin
        o_dec.aluop    = ALU_SHIFT;
        o_dec.imm_sel  = 1'b1;
        o_dec.is_write = 1'b1;
        o_dec.sh_type  = SH_SRA;
        o_dec.latency  = lat_cnt(LAT_SHIFT);
      end
      OP_ROR: begin
        o_dec.aluop    = ALU_SHIFT;
        o_dec.imm_sel  = 1'b1;
        o_dec.is_write = 1'b1;
        o_dec.sh_type  = SH_ROR;
        o_dec.latency  = lat_cnt(LAT_SHIFT);
      end
      default: begin
        o_dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle decoder/sequencer: accept, hold decoded controls through EXEC, commit once.
module control_unit
  import cpu_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_instr_valid,
  output logic               o_instr_ready,
  input  logic               i_zero,
  output logic [ALUOP_W-1:0] o_aluop,
  output logic [ADDR_W-1:0]  o_read_addr1,
  output logic [ADDR_W-1:0]  o_read_addr2,
  output logic [ADDR_W-1:0]  o_write_addr,
  output logic [DATA_W-1:0]  o_imm,
  output logic               o_imm_sel,
  output logic               o_neg_sel,
  output logic               o_write_en,
  output logic               o_branch_taken,
  output logic [DATA_W-1:0]  o_branch_offset,
  output logic               o_busy,
  output logic               o_illegal
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_instr_ready;
  logic               r_busy;
  logic [ALUOP_W-1:0] r_aluop;
  logic [ADDR_W-1:0]  r_read_addr1;
  logic [ADDR_W-1:0]  r_read_addr2;
  logic [ADDR_W-1:0]  r_write_addr;
  logic [DATA_W-1:0]  r_imm;
  logic               r_imm_sel;
  logic               r_neg_sel;
  logic [DATA_W-1:0]  r_branch_offset;
  logic               r_is_write;
  logic               r_illegal_op;
  br_kind_t           r_branch_kind;
  logic               r_write_en;
  logic               r_illegal;

  dec_t               w_dec;
  logic               w_accept;
  logic [DATA_W-1:0]  w_imm;
  logic               w_branch_taken;
  logic               w_unused_instr;

  ctrl_decode u_decode (
    .i_opcode (i_instr[31:24]),
    .o_dec    (w_dec)
  );

  // Source-register field bits above the 3-bit address are not used.
  assign w_unused_instr = ^i_instr[15:11];

  assign w_accept = r_instr_ready & i_instr_valid;

  // Shifts carry {type, amount} in the immediate; everything else passes INSTR[7:0].
  assign w_imm = (w_dec.aluop == ALU_SHIFT)
               ? {2'b00, w_dec.sh_type, i_instr[3:0]}
               : i_instr[7:0];

  // The branch decision needs the ALU flag as it stands in COMMIT, so it is gated live.
  assign w_branch_taken = (r_state == ST_COMMIT) &&
                          ((r_branch_kind == BR_JUMP) ||
                           ((r_branch_kind == BR_EQ) &&  i_zero) ||
                           ((r_branch_kind == BR_NE) && !i_zero));

  // Sequencer FSM, latency counter and registered decode/strobe outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_instr_ready   <= 1'b0;
      r_busy          <= 1'b0;
      r_aluop         <= '0;
      r_read_addr1    <= '0;
      r_read_addr2    <= '0;
      r_write_addr    <= '0;
      r_imm           <= '0;
      r_imm_sel       <= 1'b0;
      r_neg_sel       <= 1'b0;
      r_branch_offset <= '0;
      r_is_write      <= 1'b0;
      r_illegal_op    <= 1'b0;
      r_branch_kind   <= BR_NONE;
      r_write_en      <= 1'b0;
      r_illegal       <= 1'b0;
    end else begin
      r_write_en <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state         <= ST_EXEC;
            r_cnt           <= w_dec.latency;
            r_instr_ready   <= 1'b0;
            r_busy          <= 1'b1;
            r_aluop         <= w_dec.aluop;
            r_read_addr1    <= i_instr[10:8];
            r_read_addr2    <= i_instr[2:0];
            r_write_addr    <= i_instr[18:16];
            r_imm           <= w_imm;
            r_imm_sel       <= w_dec.imm_sel;
            r_neg_sel       <= w_dec.neg_sel;
            r_branch_offset <= i_instr[23:16];
            r_is_write      <= w_dec.is_write;
            r_illegal_op    <= w_dec.illegal;
            r_branch_kind   <= w_dec.is_branch ? w_dec.branch_kind : BR_NONE;
          end else begin
            r_instr_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state    <= ST_COMMIT;
            r_cnt      <= '0;
            r_write_en <= r_is_write;
            r_illegal  <= r_illegal_op;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          r_state       <= ST_IDLE;
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_cnt         <= '0;
          r_instr_ready <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign o_instr_ready   = r_instr_ready;
  assign o_busy          = r_busy;
  assign o_aluop         = r_aluop;
  assign o_read_addr1    = r_read_addr1;
  assign o_read_addr2    = r_read_addr2;
  assign o_write_addr    = r_write_addr;
  assign o_imm           = r_imm;
  assign o_imm_sel       = r_imm_sel;
  assign o_neg_sel       = r_neg_sel;
  assign o_branch_offset = r_branch_offset;
  assign o_write_en      = r_write_en;
  assign o_illegal       = r_illegal;
  assign o_branch_taken  = w_branch_taken;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode fields, commit timing, branches, illegal, reset.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_instr;
  logic        i_instr_valid;
  logic        i_zero;
  logic        o_instr_ready;
  logic [2:0]  o_aluop;
  logic [2:0]  o_read_addr1;
  logic [2:0]  o_read_addr2;
  logic [2:0]  o_write_addr;
  logic [7:0]  o_imm;
  logic        o_imm_sel;
  logic        o_neg_sel;
  logic        o_write_en;
  logic        o_branch_taken;
  logic [7:0]  o_branch_offset;
  logic        o_busy;
  logic        o_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_instr         (i_instr),
    .i_instr_valid   (i_instr_valid),
    .o_instr_ready   (o_instr_ready),
    .i_zero          (i_zero),
    .o_aluop         (o_aluop),
    .o_read_addr1    (o_read_addr1),
    .o_read_addr2    (o_read_addr2),
    .o_write_addr    (o_write_addr),
    .o_imm           (o_imm),
    .o_imm_sel       (o_imm_sel),
    .o_neg_sel       (o_neg_sel),
    .o_write_en      (o_write_en),
    .o_branch_taken  (o_branch_taken),
    .o_branch_offset (o_branch_offset),
    .o_busy          (o_busy),
    .o_illegal       (o_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobes(input string tag, input logic we, input logic bt, input logic il);
    chk({tag, ".write_en"},     32'(o_write_en),     32'(we));
    chk({tag, ".branch_taken"}, 32'(o_branch_taken), 32'(bt));
    chk({tag, ".illegal"},      32'(o_illegal),      32'(il));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present one instruction at a negedge; return in cycle 1 with INSTR scrambled.
  task automatic send(input logic [31:0] ins);
    i_instr       = ins;
    i_instr_valid = 1'b1;
    @(negedge clk);
    i_instr_valid = 1'b0;
    i_instr       = 32'hA5A5_5A5A;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (o_instr_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".ready_wait"}, 32'(o_instr_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset       = 1'b1;
    i_instr       = 32'h0;
    i_instr_valid = 1'b0;
    i_zero        = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst.ready", 32'(o_instr_ready), 32'd0);
    chk("rst.busy",  32'(o_busy),        32'd0);
    chk("rst.aluop", 32'(o_aluop),       32'd0);
    strobes("rst", 1'b0, 1'b0, 1'b0);
    i_reset = 1'b0;
    cyc();
    chk("rst.ready_after", 32'(o_instr_ready), 32'd1);
    chk("rst.busy_after",  32'(o_busy),        32'd0);

    // ADD r4 = r1 + r2 : commit in cycle 3, ready in cycle 4
    send(32'h0204_0102);
    chk("add.aluop",   32'(o_aluop),       32'd1);
    chk("add.ra1",     32'(o_read_addr1),  32'd1);
    chk("add.ra2",     32'(o_read_addr2),  32'd2);
    chk("add.wa",      32'(o_write_addr),  32'd4);
    chk("add.imm_sel", 32'(o_imm_sel),     32'd0);
    chk("add.neg_sel", 32'(o_neg_sel),     32'd0);
    chk("add.busy",    32'(o_busy),        32'd1);
    chk("add.ready_c1",32'(o_instr_ready), 32'd0);
    strobes("add.c1", 1'b0, 1'b0, 1'b0);
    cyc();
    strobes("add.c2", 1'b0, 1'b0, 1'b0);
    cyc();
    strobes("add.c3", 1'b1, 1'b0, 1'b0);
    chk("add.ready_c3",32'(o_instr_ready), 32'd0);
    cyc();
    chk("add.ready_c4",32'(o_instr_ready), 32'd1);
    chk("add.busy_c4", 32'(o_busy),        32'd0);
    chk("add.hold",    32'(o_aluop),       32'd1);
    strobes("add.c4", 1'b0, 1'b0, 1'b0);

    // LOADI r3 = 0xF7 : commit in cycle 2
    send(32'h0003_00F7);
    chk("loadi.imm",     32'(o_imm),     32'hF7);
    chk("loadi.imm_sel", 32'(o_imm_sel), 32'd1);
    chk("loadi.aluop",   32'(o_aluop),   32'd0);
    strobes("loadi.c1", 1'b0, 1'b0, 1'b0);
    cyc();
    strobes("loadi.c2", 1'b1, 1'b0, 1'b0);
    chk("loadi.wa", 32'(o_write_addr), 32'd3);
    cyc();
    chk("loadi.ready_c3", 32'(o_instr_ready), 32'd1);

    // SRA by 3 : IMM = {00,10,0011}, commit in cycle 4
    send(32'h0C05_0203);
    chk("sra.aluop",   32'(o_aluop),   32'd5);
    chk("sra.imm",     32'(o_imm),     32'h23);
    chk("sra.imm_sel", 32'(o_imm_sel), 32'd1);
    cyc();
    strobes("sra.c2", 1'b0, 1'b0, 1'b0);
    cyc();
    strobes("sra.c3", 1'b0, 1'b0, 1'b0);
    cyc();
    strobes("sra.c4", 1'b1, 1'b0, 1'b0);
    cyc();
    chk("sra.ready_c5", 32'(o_instr_ready), 32'd1);

    // ROR by 15 and SLL by 0 : shift-amount boundaries pass through
    send(32'h0D01_020F);
    chk("ror.imm", 32'(o_imm), 32'h3F);
    wait_ready("ror");
    send(32'h0A01_0200);
    chk("sll0.imm", 32'(o_imm), 32'h00);
    wait_ready("sll0");

    // BEQ taken: ZERO glitches in EXEC, is 1 in COMMIT
    i_zero = 1'b0;
    send(32'h07FC_0102);
    chk("beq.neg_sel", 32'(o_neg_sel),       32'd1);
    chk("beq.offset",  32'(o_branch_offset), 32'hFC);
    chk("beq.aluop",   32'(o_aluop),         32'd1);
    i_zero = 1'b1;
    cyc();
    strobes("beq1.c2", 1'b0, 1'b0, 1'b0);
    cyc();
    strobes("beq1.c3", 1'b0, 1'b1, 1'b0);
    cyc();
    chk("beq1.ready", 32'(o_instr_ready), 32'd1);
    strobes("beq1.c4", 1'b0, 1'b0, 1'b0);

    // BEQ not taken: ZERO high during EXEC, low in COMMIT
    send(32'h07FC_0102);
    i_zero = 1'b1;
    cyc();
    i_zero = 1'b0;
    cyc();
    strobes("beq0.c3", 1'b0, 1'b0, 1'b0);
    cyc();
    chk("beq0.ready", 32'(o_instr_ready), 32'd1);

    // BNE with ZERO=0 is taken
    send(32'h08FC_0102);
    cyc();
    cyc();
    strobes("bne.c3", 1'b0, 1'b1, 1'b0);
    cyc();
    chk("bne.ready", 32'(o_instr_ready), 32'd1);

    // J : unconditional, LAT_FWD
    send(32'h0610_0000);
    chk("j.aluop",  32'(o_aluop),         32'd0);
    chk("j.offset", 32'(o_branch_offset), 32'h10);
    cyc();
    strobes("j.c2", 1'b0, 1'b1, 1'b0);
    cyc();
    chk("j.ready", 32'(o_instr_ready), 32'd1);

    // Illegal 0xFF with INSTR_VALID held; next instruction accepted in cycle 3
    i_instr       = 32'hFF00_0000;
    i_instr_valid = 1'b1;
    cyc();
    i_instr = 32'h0203_0405;
    i_zero  = 1'b1;
    chk("ill.busy", 32'(o_busy), 32'd1);
    cyc();
    strobes("ill.c2", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("ill.ready_c3", 32'(o_instr_ready), 32'd1);
    strobes("ill.c3", 1'b0, 1'b0, 1'b0);
    cyc();
    i_instr_valid = 1'b0;
    chk("b2b.busy",  32'(o_busy),        32'd1);
    chk("b2b.ready", 32'(o_instr_ready), 32'd0);
    chk("b2b.aluop", 32'(o_aluop),       32'd1);
    chk("b2b.ra1",   32'(o_read_addr1),  32'd4);
    chk("b2b.ra2",   32'(o_read_addr2),  32'd5);
    chk("b2b.wa",    32'(o_write_addr),  32'd3);
    cyc();
    strobes("b2b.c2", 1'b0, 1'b0, 1'b0);
    cyc();
    strobes("b2b.c3", 1'b1, 1'b0, 1'b0);
    cyc();
    chk("b2b.ready_c4", 32'(o_instr_ready), 32'd1);

    // MULT interrupted by RESET in EXEC cycle 2
    i_zero = 1'b0;
    send(32'h0901_0203);
    chk("mul.aluop", 32'(o_aluop), 32'd4);
    cyc();
    i_reset = 1'b1;
    cyc();
    chk("mrst.ready",   32'(o_instr_ready),   32'd0);
    chk("mrst.busy",    32'(o_busy),          32'd0);
    chk("mrst.aluop",   32'(o_aluop),         32'd0);
    chk("mrst.ra1",     32'(o_read_addr1),    32'd0);
    chk("mrst.ra2",     32'(o_read_addr2),    32'd0);
    chk("mrst.wa",      32'(o_write_addr),    32'd0);
    chk("mrst.imm",     32'(o_imm),           32'd0);
    chk("mrst.imm_sel", 32'(o_imm_sel),       32'd0);
    chk("mrst.neg_sel", 32'(o_neg_sel),       32'd0);
    chk("mrst.offset",  32'(o_branch_offset), 32'd0);
    strobes("mrst", 1'b0, 1'b0, 1'b0);
    i_reset = 1'b0;
    cyc();
    chk("mrst.ready_after", 32'(o_instr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      strobes("mrst.quiet", 1'b0, 1'b0, 1'b0);
      chk("mrst.quiet.busy", 32'(o_busy), 32'd0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
